// File: rtl/logic16_stage_pkg.sv
// Shared opcode encodings, default geometry and occupancy states for the logic16 stage.
package logic16_stage_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'b00,
        OCC_PARTIAL = 2'b01,
        OCC_FULL    = 2'b10
    } occ_state_e;

endpackage

// File: rtl/And16.sv
// Bitwise AND from the 16-bit gate bank.
module And16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = a_i & b_i;
endmodule

// File: rtl/Not16.sv
// Bitwise inverter from the 16-bit gate bank.
module Not16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = ~a_i;
endmodule

// File: rtl/Or16.sv
// Bitwise OR from the 16-bit gate bank.
module Or16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = a_i | b_i;
endmodule

// File: rtl/result_fifo.sv
// Result FIFO with an explicit EMPTY/PARTIAL/FULL controller; push/pop are pre-qualified by the caller.
module result_fifo
    import logic16_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [OW-1:0]    occ_q;
    logic [OW-1:0]    occ_d;
    occ_state_e       state_q;

    always_comb begin
        occ_d = occ_q;
        if (push_i && !pop_i) begin
            occ_d = occ_q + OW'(1);
        end else if (pop_i && !push_i) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            state_q  <= OCC_EMPTY;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            occ_q <= occ_d;
            case (state_q)
                OCC_EMPTY: begin
                    if (push_i) state_q <= OCC_PARTIAL;
                end
                OCC_PARTIAL: begin
                    if (push_i && !pop_i && occ_q == OW'(DEPTH - 1)) begin
                        state_q <= OCC_FULL;
                    end else if (pop_i && !push_i && occ_q == OW'(1)) begin
                        state_q <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop_i) state_q <= OCC_PARTIAL;
                end
                default: state_q <= OCC_EMPTY;
            endcase
        end
    end

    // Storage is data only: never reset, masked by empty_o on the read side.
    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign full_o  = (state_q == OCC_FULL);
    assign empty_o = (state_q == OCC_EMPTY);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/logic16_stage.sv
// Flow-controlled logic stage: NOT/AND/OR/XOR on the gate bank, buffered results, Hack zr/ng flags
// and an accepted-operation counter.
module logic16_stage
    import logic16_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zr,
    output logic             out_ng,
    output logic [15:0]      count
);
    logic [WIDTH-1:0] not_a;
    logic [WIDTH-1:0] and_ab;
    logic [WIDTH-1:0] or_ab;
    logic [WIDTH-1:0] nand_ab;
    logic [WIDTH-1:0] xor_ab;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             rst_hold_q;
    logic [15:0]      count_q;
    logic [15:0]      count_d;

    Not16 #(.WIDTH(WIDTH)) u_not_a  (.a_i(a),      .y_o(not_a));
    And16 #(.WIDTH(WIDTH)) u_and_ab (.a_i(a),      .b_i(b),       .y_o(and_ab));
    Or16  #(.WIDTH(WIDTH)) u_or_ab  (.a_i(a),      .b_i(b),       .y_o(or_ab));
    // XOR built from the bank: (a | b) & ~(a & b).
    Not16 #(.WIDTH(WIDTH)) u_nand   (.a_i(and_ab), .y_o(nand_ab));
    And16 #(.WIDTH(WIDTH)) u_xor    (.a_i(or_ab),  .b_i(nand_ab), .y_o(xor_ab));

    always_comb begin
        result = not_a;
        case (op_e'(op))
            OP_NOT:  result = not_a;
            OP_AND:  result = and_ab;
            OP_OR:   result = or_ab;
            OP_XOR:  result = xor_ab;
            default: result = not_a;
        endcase
    end

    // rst_hold_q keeps in_ready low for every cycle that follows a reset edge while reset persists.
    assign in_ready  = !rst_hold_q && !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    result_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (result),
        .rdata_o (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_zr = (out_data == '0);
    assign out_ng = out_data[WIDTH-1];

    always_comb begin
        count_d = count_q;
        if (push) count_d = count_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        rst_hold_q <= reset;
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_logic16_stage.sv
// Scoreboard bench for logic16_stage: directed pushes queue expected results, a monitor checks pops.
module tb_logic16_stage
    import logic16_stage_pkg::*;
;
    typedef struct packed {
        logic [15:0] d;
        logic        zr;
        logic        ng;
    } exp_t;

    localparam int BULK = 65534 - 22;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zr;
    logic        out_ng;
    logic [15:0] count;

    int   checks;
    int   failures;
    exp_t sb[$];
    exp_t cur_exp;

    logic16_stage #(.WIDTH(16), .DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zr    (out_zr),
        .out_ng    (out_ng),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: pops are checked against the queue, accepted pushes enqueue their expectation.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pop", {15'd0, out_zr, out_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pop_result", {14'd0, out_zr, out_ng, out_data}, {14'd0, e.zr, e.ng, e.d});
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(cur_exp);
        end
    end

    task automatic push(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] e, output int waited);
        bit acc;
        op       = o;
        a        = x;
        b        = y;
        cur_exp  = '{d: e, zr: (e == 16'h0000), ng: e[15]};
        in_valid = 1'b1;
        acc      = 1'b0;
        waited   = 0;
        while (!acc && waited < 50) begin
            @(negedge clock);
            if (in_ready === 1'b1) acc = 1'b1;
            @(posedge clock);
            #1;
            waited++;
        end
        if (!acc) chk("push_timeout", 32'(waited), 32'd0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (out_valid === 1'b1 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'b00;
        a         = '0;
        b         = '0;
        cur_exp   = '0;

        // Reset for two cycles
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_data", {15'd0, out_zr, out_data}, 32'h0001_0000);
            chk("rst_count", {16'd0, count}, 32'd0);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single AND op with one-cycle latency
        out_ready = 1'b1;
        chk("single_pre_empty", {31'd0, out_valid}, 32'd0);
        push(OP_AND, 16'h0095, 16'h00BA, 16'h0090, w);
        chk("single_latency_valid", {31'd0, out_valid}, 32'd1);
        chk("single_head", {14'd0, out_zr, out_ng, out_data}, 32'h0000_0090);
        chk("single_count", {16'd0, count}, 32'd1);
        idle();
        drain();

        // All ops on the same operands
        push(OP_NOT, 16'h0095, 16'h00BA, 16'hFF6A, w);
        push(OP_OR,  16'h0095, 16'h00BA, 16'h00BF, w);
        push(OP_XOR, 16'h0095, 16'h00BA, 16'h002F, w);
        push(OP_AND, 16'h00F0, 16'h0F0F, 16'h0000, w);
        idle();
        drain();
        chk("allops_count", {16'd0, count}, 32'd5);

        // Backpressure: four fill the FIFO, fifth is held
        out_ready = 1'b0;
        push(OP_OR,  16'h1200, 16'h0034, 16'h1234, w);
        push(OP_AND, 16'hFFFF, 16'h8001, 16'h8001, w);
        push(OP_XOR, 16'hAAAA, 16'h5555, 16'hFFFF, w);
        push(OP_NOT, 16'hFFFF, 16'h1111, 16'h0000, w);
        chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        op       = OP_OR;
        a        = 16'h0F00;
        b        = 16'h00F0;
        cur_exp  = '{d: 16'h0FF0, zr: 1'b0, ng: 1'b0};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_count", {16'd0, count}, 32'd9);
        end
        out_ready = 1'b1;
        push(OP_OR, 16'h0F00, 16'h00F0, 16'h0FF0, w);
        idle();
        drain();
        chk("bp_count", {16'd0, count}, 32'd10);

        // Simultaneous push/pop at occupancy 2
        out_ready = 1'b0;
        push(OP_OR,  16'h00A0, 16'h000B, 16'h00AB, w);
        push(OP_AND, 16'hC3C3, 16'hFF00, 16'hC300, w);
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            push(OP_OR, 16'(i), 16'(i << 8), 16'((i << 8) | i), w);
            chk("simul_first_try", 32'(w), 32'd1);
            chk("simul_in_ready", {31'd0, in_ready}, 32'd1);
        end
        idle();
        chk("simul_count", {16'd0, count}, 32'd22);
        drain();

        // Counter wrap via bulk pushes
        op       = OP_AND;
        a        = 16'h1234;
        b        = 16'h0000;
        cur_exp  = '{d: 16'h0000, zr: 1'b1, ng: 1'b0};
        in_valid = 1'b1;
        repeat (BULK) @(posedge clock);
        #1;
        idle();
        chk("wrap_pre_count", {16'd0, count}, 32'h0000_FFFE);
        push(OP_NOT, 16'h7FFF, 16'h0000, 16'h8000, w);
        idle();
        chk("wrap_ffff", {16'd0, count}, 32'h0000_FFFF);
        push(OP_XOR, 16'h00FF, 16'hFF00, 16'hFFFF, w);
        idle();
        chk("wrap_zero", {16'd0, count}, 32'd0);
        drain();

        // Mid-operation reset with three stale entries
        out_ready = 1'b0;
        push(OP_OR,  16'hDE00, 16'h00AD, 16'hDEAD, w);
        push(OP_NOT, 16'h0000, 16'h0000, 16'hFFFF, w);
        push(OP_XOR, 16'h1234, 16'h1234, 16'h0000, w);
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_data", {15'd0, out_zr, out_data}, 32'h0001_0000);
        chk("midrst_count", {16'd0, count}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        push(OP_XOR, 16'h0F0F, 16'h00FF, 16'h0FF0, w);
        idle();
        chk("midrst_new_count", {16'd0, count}, 32'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
